// File: rtl/pipe_ctrl_unit.sv
// Pipelined control for a 5-stage core: ID decode, ID/EX, EX/MEM, MEM/WB control registers,
// load-use bubble insertion, external stall/flush handling and saturating illegal-opcode count.
module pipe_ctrl_unit #(
  parameter int OPCODE_W = 4,
  parameter int REG_W    = 3,
  parameter int CNT_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [OPCODE_W-1:0] id_opcode,
  input  logic [REG_W-1:0]    id_rs,
  input  logic [REG_W-1:0]    id_rt,
  input  logic [REG_W-1:0]    id_rd,
  input  logic                stall_ext,
  input  logic                flush,
  output logic                hazard_stall,
  output logic                ex_valid,
  output logic                ex_alu_src,
  output logic [1:0]          ex_alu_op,
  output logic [REG_W-1:0]    ex_rd,
  output logic                mem_mr,
  output logic                mem_mw,
  output logic [REG_W-1:0]    mem_rd,
  output logic                wb_en_rw,
  output logic                wb_mreg,
  output logic [REG_W-1:0]    wb_rd,
  output logic                illegal_pulse,
  output logic [CNT_W-1:0]    illegal_cnt
);

  logic       hi_bits;
  logic       dec_alu_src, dec_mr, dec_mw, dec_en_rw, dec_mreg, dec_illegal, dec_uses_rt;
  logic [1:0] dec_alu_op;

  generate
    if (OPCODE_W > 4) begin : g_hi
      assign hi_bits = |id_opcode[OPCODE_W-1:4];
    end else begin : g_no_hi
      assign hi_bits = 1'b0;
    end
  endgenerate

  always_comb begin
    dec_alu_src = 1'b0;
    dec_mr      = 1'b0;
    dec_mw      = 1'b0;
    dec_en_rw   = 1'b0;
    dec_mreg    = 1'b0;
    dec_alu_op  = 2'b00;
    dec_illegal = 1'b0;
    dec_uses_rt = 1'b0;
    if (hi_bits) begin
      dec_illegal = 1'b1;
    end else begin
      case (id_opcode[3:0])
        4'b0000: begin dec_en_rw = 1'b1; dec_uses_rt = 1'b1; end
        4'b0001: begin dec_en_rw = 1'b1; dec_alu_op = 2'b01; dec_uses_rt = 1'b1; end
        4'b0010: begin
          dec_alu_src = 1'b1; dec_mr = 1'b1; dec_en_rw = 1'b1; dec_mreg = 1'b1; dec_alu_op = 2'b11;
        end
        4'b0011: begin dec_alu_src = 1'b1; dec_mw = 1'b1; dec_alu_op = 2'b11; dec_uses_rt = 1'b1; end
        4'b0111: begin dec_alu_src = 1'b1; dec_en_rw = 1'b1; dec_alu_op = 2'b10; end
        4'b1111: begin dec_en_rw = 1'b1; dec_alu_op = 2'b11; dec_uses_rt = 1'b1; end
        default: dec_illegal = 1'b1;
      endcase
    end
  end

  // Downstream control bits that ride in ID/EX and EX/MEM without being ports there.
  logic ex_mr, ex_mw, ex_en_rw, ex_mreg;
  logic mem_en_rw, mem_mreg;
  logic hz, load_id;

  // The lw still sitting in EX is what a dependent ID instruction must wait on.
  assign hz = id_valid & ex_valid & ex_mr &
              ((ex_rd == id_rs) | (dec_uses_rt & (ex_rd == id_rt)));
  assign hazard_stall = hz & ~flush;
  assign load_id = ~flush & ~stall_ext & ~hz & id_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid   <= 1'b0;
      ex_alu_src <= 1'b0;
      ex_alu_op  <= 2'b00;
      ex_rd      <= '0;
      ex_mr      <= 1'b0;
      ex_mw      <= 1'b0;
      ex_en_rw   <= 1'b0;
      ex_mreg    <= 1'b0;
    end else if (flush || (!stall_ext && !load_id)) begin
      ex_valid   <= 1'b0;
      ex_alu_src <= 1'b0;
      ex_alu_op  <= 2'b00;
      ex_rd      <= '0;
      ex_mr      <= 1'b0;
      ex_mw      <= 1'b0;
      ex_en_rw   <= 1'b0;
      ex_mreg    <= 1'b0;
    end else if (load_id) begin
      ex_valid   <= 1'b1;
      ex_alu_src <= dec_alu_src;
      ex_alu_op  <= dec_alu_op;
      ex_rd      <= id_rd;
      ex_mr      <= dec_mr;
      ex_mw      <= dec_mw;
      ex_en_rw   <= dec_en_rw;
      ex_mreg    <= dec_mreg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_mr    <= 1'b0;
      mem_mw    <= 1'b0;
      mem_rd    <= '0;
      mem_en_rw <= 1'b0;
      mem_mreg  <= 1'b0;
      wb_en_rw  <= 1'b0;
      wb_mreg   <= 1'b0;
      wb_rd     <= '0;
    end else if (!stall_ext) begin
      mem_mr    <= ex_mr;
      mem_mw    <= ex_mw;
      mem_rd    <= ex_rd;
      mem_en_rw <= ex_en_rw;
      mem_mreg  <= ex_mreg;
      wb_en_rw  <= mem_en_rw;
      wb_mreg   <= mem_mreg;
      wb_rd     <= mem_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      illegal_pulse <= 1'b0;
      illegal_cnt   <= '0;
    end else begin
      illegal_pulse <= load_id & dec_illegal;
      if (load_id && dec_illegal && (illegal_cnt != {CNT_W{1'b1}}))
        illegal_cnt <= illegal_cnt + 1'b1;
    end
  end

endmodule

// File: doc/pipe_ctrl_unit.md
# pipe_ctrl_unit

Pipelined control unit for the 5-stage RISC core. Decodes the ID-stage opcode into control bits, then carries them through the ID/EX, EX/MEM and MEM/WB control registers so each stage sees the bits belonging to its own instruction. It adds three things on top of the flat decoder:

- a load opcode;
- load-use hazard detection with bubble insertion;
- external stall/flush handling and illegal-opcode accounting.

## Interface

Parameters:
- OPCODE_W, 4: opcode width, ≥4. Any set bit above bit 3 makes the opcode illegal.
- REG_W, 3: register address width.
- CNT_W, 8: width of the illegal-opcode counter.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_opcode  in  OPCODE_W  opcode in ID.
- id_rs, id_rt, id_rd  in  REG_W each  source and destination register fields in ID.
- stall_ext  in  1  downstream stall; freezes EX/MEM and MEM/WB.
- flush  in  1  redirect; the ID instruction must not enter EX.
- hazard_stall  out  1  combinational; upstream must hold PC and IF/ID.
- ex_valid, ex_alu_src  out  1 each  EX-stage control bits.
- ex_alu_op  out  2  EX-stage ALU operation.
- ex_rd  out  REG_W  EX-stage destination register.
- mem_mr, mem_mw  out  1 each  MEM-stage control bits.
- mem_rd  out  REG_W  MEM-stage destination register.
- wb_en_rw, wb_mreg  out  1 each  WB-stage control bits.
- wb_rd  out  REG_W  WB-stage destination register.
- illegal_pulse  out  1  one-cycle pulse when an illegal valid opcode enters EX.
- illegal_cnt  out  CNT_W  saturating count of illegal opcodes.

## Operation

Decode (combinational, ID stage), as ALU_Src/MR/MW/EnRW/MReg/ALU_Op:
- 0000 nor: 0/0/0/1/0/00.
- 0001 nand: 0/0/0/1/0/01.
- 0010 lw: 1/1/0/1/1/11.
- 0011 sw: 1/0/1/0/0/11.
- 0111 xnori: 1/0/0/1/0/10.
- 1111 add: 0/0/0/1/0/11.
- Any other value, or a set bit above bit 3: all zeros and flagged illegal. MReg is always driven, so there are no latches.

Register use:
- rt is read by nor, nand, add and sw.
- rs is read by every legal opcode.

Load-use hazard:
- hz = id_valid & ex_valid & mem_mr_next & (ex_rd==id_rs | (uses_rt & ex_rd==id_rt)).
- mem_mr_next is the MR bit held in ID/EX.
- There is no zero-register exemption.
- hazard_stall = hz & ~flush.

ID/EX update, in priority order:
1. rst: load zeros.
2. flush: load a bubble.
3. stall_ext: hold.
4. hz: load a bubble.
5. ~id_valid: load a bubble.
6. Otherwise: load the decoded bits and id_rd.

Bubble definition:
- A bubble has all control bits 0, valid 0 and rd 0.
- An illegal opcode enters as valid=1 with all-zero controls, so it has no architectural effect.

EX/MEM and MEM/WB:
- Both shift forward each cycle unless stall_ext is set, in which case both hold.
- On rst, both load zeros.

Illegal opcode accounting:
- illegal_pulse is registered. It is set in the cycle an illegal valid instruction is loaded into ID/EX, and 0 otherwise, including under stall_ext.
- illegal_cnt increments on that same event and saturates at all-ones.

## Timing

- Reset: every output is 0, including illegal_cnt. hazard_stall is 0 because ex_valid=0.
- Latency: an instruction in ID at cycle N gives ex_* at N+1, mem_* at N+2 and wb_* at N+3, absent stalls.
- Hazard:
  - hazard_stall is asserted in the same cycle as the offending ID instruction.
  - One bubble is inserted, so the dependent instruction reaches EX one cycle later.
  - hz clears automatically once the lw leaves EX.
- flush and hz together: flush wins; hazard_stall=0 and ID/EX gets a bubble.
- flush and stall_ext together: ID/EX gets a bubble; EX/MEM and MEM/WB hold.
- stall_ext for k cycles: all stage outputs are frozen for k cycles. hazard_stall keeps being evaluated against the frozen EX contents.
- rst mid-stream: the next edge clears all three stages and the counter. Instructions in flight are discarded.
- Counter at 2^CNT_W−1: further illegal opcodes leave it unchanged, and illegal_pulse still fires.

## Test plan

- Reset, then add (1111) with rd=5 in ID → at N+1 ex_alu_op=11, ex_alu_src=0; at N+3 wb_en_rw=1, wb_mreg=0, wb_rd=5.
- lw rd=3, then nand rs=3 back-to-back → hazard_stall=1 for exactly one cycle, one bubble in EX (ex_valid=0), nand reaches EX one cycle after the bubble.
- lw rd=3, then xnori rs=2 rt=3 → no hazard, because xnori does not read rt; hazard_stall stays 0.
- sw, then stall_ext held 3 cycles → mem_mw=1 held for 4 cycles total; wb_en_rw=0 when sw reaches WB.
- Opcode 0101 valid → illegal_pulse=1 for one cycle, illegal_cnt=1, all EX controls 0. With CNT_W=2 and 5 illegal opcodes, illegal_cnt=3.
- flush asserted with a lw-use hazard present → hazard_stall=0, ex_valid=0 next cycle. rst asserted mid-pipe → all outputs 0 on the next edge.
